sdp_bram_stream_reader: RTL and testbench
=========================================

Name: sdp_bram_stream_reader

Overview:
- Read-side controller for the simple-dual-port BRAM macro family: it drains a block of words from the BRAM read port and presents them as a valid/ready stream.
- A command gives a base address and a word count. The block issues RDEN/RDADDR, absorbs the fixed 1-cycle BRAM read latency (DO_REG=0), and holds data in a 2-entry skid FIFO so downstream backpressure never loses a word.
- It sits between a BRAM instance (READ_FIRST, read width = DATA_WIDTH) and a consumer such as a DMA or NAND channel datapath.

Parameters:
- DATA_WIDTH, 32, BRAM read-port width and stream data width.
- ADDR_WIDTH, 9, BRAM read-address width; depth = 2^ADDR_WIDTH.
- LEN_WIDTH, 10, command length width (must be ≥ ADDR_WIDTH+1).

Ports:
- iClock  in  1  single clock; also drives the BRAM RDCLK.
- iResetN  in  1  asynchronous active-low reset.
- iStart  in  1  command strobe; accepted only when oBusy=0.
- iBaseAddr  in  ADDR_WIDTH  first word address.
- iLength  in  LEN_WIDTH  number of words to read; 0 is legal.
- oBusy  out  1  command in progress.
- oDone  out  1  one-cycle pulse when the command completes.
- oRdEn  out  1  to BRAM RDEN.
- oRdAddr  out  ADDR_WIDTH  to BRAM RDADDR.
- iRdData  in  DATA_WIDTH  from BRAM DO; valid the cycle after the oRdEn edge.
- oValid  out  1  stream data valid.
- oData  out  DATA_WIDTH  stream data.
- oLast  out  1  marks the final word of the command; qualified by oValid.
- iReady  in  1  consumer accepts when oValid && iReady.

Behaviour:
- Reset (async assert, sync deassert by system): state=IDLE; oBusy, oDone, oRdEn, oValid, oLast = 0; oRdAddr, oData = 0; FIFO empty; counters 0.
- States:
  - IDLE -> RUN on iStart with iLength≠0.
  - IDLE -> IDLE with an oDone pulse on the next cycle when iStart with iLength=0; no reads are issued.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> IDLE when the last word is accepted (oValid && iReady && oLast); oDone pulses in the cycle after that edge.
- oBusy = 1 in RUN and DRAIN.
- iStart while oBusy=1 is ignored (no queueing).
- Read issue:
  - oRdEn is a combinational function of registered state: RUN && (occ + inflight − pop) < 2.
  - occ = FIFO count (0..2); inflight = oRdEn registered one cycle; pop = oValid && iReady.
  - oRdAddr starts at iBaseAddr and increments by 1 per issued read, wrapping mod 2^ADDR_WIDTH (e.g. 511 -> 0 for ADDR_WIDTH=9).
  - oRdAddr holds its value while oRdEn=0.
- Capture: iRdData is written into the FIFO on the edge after each issued read; a word is never dropped and never duplicated.
- Latency:
  - iStart sampled at edge E0 -> oRdEn=1 with oRdAddr=base in the cycle after E0.
  - BRAM samples the address at E1; data is captured at E2; oValid=1 after E2.
- Throughput: with iReady held high, one word per cycle after the first.
- Stream rules:
  - oData, oLast stable while oValid && !iReady.
  - oValid never drops without acceptance.
- oLast: set on the word whose index = iLength−1; the word counter is LEN_WIDTH wide.
- Length rules:
  - iLength > 2^ADDR_WIDTH wraps addresses and rereads.
  - iLength = 2^ADDR_WIDTH reads each location exactly once.
- Simultaneous FIFO push and pop at occ=2 cannot occur (credit rule); push and pop at occ=1 leaves occ=1.
- Reset mid-command: everything returns to reset values immediately; no oDone is generated; any in-flight BRAM data is discarded.

Test Plan:
- base=0x010, len=4, iReady=1 -> oRdAddr 0x010..0x013 on consecutive cycles; oValid 4 consecutive cycles with mem[0x10..0x13]; oLast on the 4th; oDone 1 cycle later; oBusy low after.
- base=0x1FE, len=4 (ADDR_WIDTH=9) -> addresses 0x1FE, 0x1FF, 0x000, 0x001; data in that order.
- len=8, iReady toggling 1,0,0,1,0,1,… -> oRdEn never makes occ+inflight exceed 2; all 8 words delivered in order, each exactly once; oData stable while stalled.
- len=0 -> no oRdEn, no oValid, oDone pulse 1 cycle after start; second iStart pulsed during a len=6 run -> ignored, exactly 6 words output.
- len=512 from base 0x000 -> 512 words, oLast only on word 511, single oDone.
- iResetN low for 1 cycle after the 3rd word of len=10 -> all outputs 0 immediately; no oDone; new command base=0x020, len=2 afterwards completes normally.

Source files
------------

// File: rtl/sdp_bram_stream_reader.sv
// Drains a block of words from a simple-dual-port BRAM read port (1-cycle latency)
// and presents them as a valid/ready stream, buffered by a 2-entry skid FIFO.
//
// state  | meaning
// S_IDLE | waiting for a command; zero-length commands finish here
// S_RUN  | issuing reads, throttled by FIFO credit
// S_DRAIN| all reads issued; waiting for the last word to be accepted
module sdp_bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  iClock,
    input  logic                  iResetN,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddr,
    input  logic [LEN_WIDTH-1:0]  iLength,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oRdEn,
    output logic [ADDR_WIDTH-1:0] oRdAddr,
    input  logic [DATA_WIDTH-1:0] iRdData,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oLast,
    input  logic                  iReady
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt_q;
    logic [LEN_WIDTH-1:0]  cap_cnt_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  inflight_q;
    logic                  done_q;

    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;
    logic                  last0_q, last1_q;

    logic [2:0] pending;
    logic       valid_w;
    logic       pop;
    logic       rd_en;
    logic       last_issue;
    logic       start_run;
    logic       start_zero;
    logic       last_pop;
    logic       push_last;
    logic       done_d;

    assign valid_w   = (occ_q != 2'd0);
    assign pop       = valid_w && iReady;
    assign push_last = (cap_cnt_q == len_q - LEN_WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        pending    = {1'b0, occ_q} + {2'b00, inflight_q};
        // Credit: words already buffered or in the BRAM pipe, less the one leaving now.
        rd_en      = (state_q == S_RUN) && (pending < (3'd2 + {2'b00, pop}));
        last_issue = rd_en && (issue_cnt_q == len_q - LEN_WIDTH'(1));
        start_run  = (state_q == S_IDLE) && iStart && (iLength != '0);
        start_zero = (state_q == S_IDLE) && iStart && (iLength == '0);
        last_pop   = (state_q == S_DRAIN) && pop && last0_q;
        done_d     = start_zero || last_pop;

        case (state_q)
            S_IDLE:  if (start_run)  state_d = S_RUN;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (last_pop)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= rd_en;
            if (start_run) begin
                len_q       <= iLength;
                rd_addr_q   <= iBaseAddr;
                issue_cnt_q <= '0;
                cap_cnt_q   <= '0;
            end else begin
                if (rd_en) begin
                    rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
                    issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
                end
                if (inflight_q) begin
                    cap_cnt_q <= cap_cnt_q + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Skid FIFO: entry 0 is always the head presented on the stream.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data0_q <= iRdData;
                        last0_q <= push_last;
                    end else begin
                        data1_q <= iRdData;
                        last1_q <= push_last;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        data0_q <= iRdData;
                        last0_q <= push_last;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= iRdData;
                        last1_q <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oBusy   = (state_q != S_IDLE);
    assign oDone   = done_q;
    assign oRdEn   = rd_en;
    assign oRdAddr = rd_addr_q;
    assign oValid  = valid_w;
    assign oData   = data0_q;
    assign oLast   = valid_w && last0_q;

endmodule

// File: tb/tb_sdp_bram_stream_reader.sv
// Directed bench for sdp_bram_stream_reader with a behavioural 1-cycle BRAM
// and a stream monitor that records issued reads, accepted words and oDone pulses.
module tb_sdp_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int LW = 10;

    logic          iClock    = 1'b0;
    logic          iResetN   = 1'b0;
    logic          iStart    = 1'b0;
    logic [AW-1:0] iBaseAddr = '0;
    logic [LW-1:0] iLength   = '0;
    logic [DW-1:0] iRdData   = '0;
    logic          iReady    = 1'b1;
    logic          oBusy, oDone, oRdEn, oValid, oLast;
    logic [AW-1:0] oRdAddr;
    logic [DW-1:0] oData;

    sdp_bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .iClock   (iClock),
        .iResetN  (iResetN),
        .iStart   (iStart),
        .iBaseAddr(iBaseAddr),
        .iLength  (iLength),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oRdEn    (oRdEn),
        .oRdAddr  (oRdAddr),
        .iRdData  (iRdData),
        .oValid   (oValid),
        .oData    (oData),
        .oLast    (oLast),
        .iReady   (iReady)
    );

    always #5 iClock = ~iClock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_word(input int a);
        return {16'hB0A0 + 16'(a), 16'(a * 7) ^ 16'h5A5A};
    endfunction

    logic [DW-1:0] mem [512];

    initial begin
        forever begin
            @(posedge iClock);
            if (oRdEn) iRdData <= mem[oRdAddr];
        end
    end

    bit stall_mode = 1'b0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        int pidx = 0;
        forever begin
            @(posedge iClock);
            #1;
            if (stall_mode) begin
                iReady = pat[pidx];
                pidx = (pidx + 1) % 6;
            end else begin
                iReady = 1'b1;
            end
        end
    end

    logic [DW-1:0] words [$];
    bit            lasts [$];
    int            acc_cyc [$];
    logic [AW-1:0] raddrs [$];
    int            rd_cyc [$];
    int  cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int  outstanding = 0, credit_err = 0, stall_err = 0, stall_cnt = 0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    initial begin
        forever begin
            @(negedge iClock);
            cyc++;
            if (!iResetN) begin
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (prev_stall && !(oValid && oData == prev_data && oLast == prev_last)) stall_err++;
                if (iStart) start_cyc = cyc;
                if (oRdEn) begin
                    raddrs.push_back(oRdAddr);
                    rd_cyc.push_back(cyc);
                    outstanding++;
                end
                if (oValid && iReady) begin
                    words.push_back(oData);
                    lasts.push_back(oLast);
                    acc_cyc.push_back(cyc);
                    outstanding--;
                end
                if (outstanding > 2) credit_err++;
                if (oDone) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = oValid && !iReady;
                if (prev_stall) stall_cnt++;
                prev_data = oData;
                prev_last = oLast;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] base, input logic [LW-1:0] len);
        @(posedge iClock);
        #1;
        iStart = 1'b1; iBaseAddr = base; iLength = len;
        @(posedge iClock);
        #1;
        iStart = 1'b0;
    endtask

    // Runs one command to completion and compares reads, words, oLast and oDone.
    // ign >= 0 pulses a second (ignored) start that many cycles into the run.
    task automatic run_cmd(input string t, input logic [AW-1:0] base, input logic [LW-1:0] len, input int ign);
        int w0 = words.size();
        int a0 = raddrs.size();
        int d0 = done_cnt;
        int L  = int'(len);
        int n  = 0;
        int nw, na;
        logic [AW-1:0] ea;
        pulse_start(base, len);
        if (ign >= 0) begin
            repeat (ign) @(posedge iClock);
            #1;
            iStart = 1'b1; iBaseAddr = 9'h100; iLength = 10'd3;
            @(posedge iClock);
            #1;
            iStart = 1'b0;
        end
        while (done_cnt == d0 && n < 3000) begin
            @(negedge iClock);
            n++;
        end
        check({t, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
        @(negedge iClock);
        check({t, "_busy_after"}, 64'(oBusy), 64'd0);
        repeat (3) @(negedge iClock);
        check({t, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        nw = words.size() - w0;
        na = raddrs.size() - a0;
        check({t, "_nwords"}, 64'(nw), 64'(L));
        check({t, "_nreads"}, 64'(na), 64'(L));
        for (int i = 0; i < L && i < nw && i < na; i++) begin
            ea = base + AW'(i);
            check($sformatf("%s_addr%0d", t, i), 64'(raddrs[a0 + i]), 64'(ea));
            check($sformatf("%s_data%0d", t, i), 64'(words[w0 + i]), 64'(exp_word(int'(ea))));
            check($sformatf("%s_last%0d", t, i), 64'(lasts[w0 + i]), 64'(i == L - 1));
        end
    endtask

    initial begin
        int w0, d0, n, s;
        for (int i = 0; i < 512; i++) mem[i] = exp_word(i);

        iResetN = 1'b0;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        check("rst_busy",  64'(oBusy),   64'd0);
        check("rst_done",  64'(oDone),   64'd0);
        check("rst_rden",  64'(oRdEn),   64'd0);
        check("rst_valid", 64'(oValid),  64'd0);
        check("rst_last",  64'(oLast),   64'd0);
        check("rst_addr",  64'(oRdAddr), 64'd0);
        check("rst_data",  64'(oData),   64'd0);
        @(posedge iClock);
        #1;
        iResetN = 1'b1;
        repeat (2) @(posedge iClock);

        // base 0x010 len 4, ready high: timing relative to the start-sample edge
        run_cmd("t1", 9'h010, 10'd4, -1);
        s = start_cyc;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rdcyc%0d", i),  64'(rd_cyc[i]),  64'(s + 1 + i));
            check($sformatf("t1_acccyc%0d", i), 64'(acc_cyc[i]), 64'(s + 3 + i));
        end
        check("t1_donecyc", 64'(done_cyc), 64'(s + 7));

        run_cmd("t2_wrap", 9'h1FE, 10'd4, -1);

        stall_mode = 1'b1;
        run_cmd("t3_stall", 9'h040, 10'd8, -1);
        stall_mode = 1'b0;
        check("t3_stall_stable", 64'(stall_err), 64'd0);
        check("t3_credit", 64'(credit_err), 64'd0);
        check("t3_stalled", 64'(stall_cnt > 0), 64'd1);

        run_cmd("t4_zero", 9'h055, 10'd0, -1);
        check("t4_zero_donecyc", 64'(done_cyc), 64'(start_cyc + 1));

        run_cmd("t4_ign", 9'h0A0, 10'd6, 3);

        run_cmd("t5_full", 9'h000, 10'd512, -1);
        check("t5_credit", 64'(credit_err), 64'd0);

        // reset in the middle of a 10-word command
        w0 = words.size();
        d0 = done_cnt;
        pulse_start(9'h180, 10'd10);
        n = 0;
        while (words.size() < w0 + 3 && n < 200) begin
            @(negedge iClock);
            n++;
        end
        check("t6_three_words", 64'(words.size() >= w0 + 3), 64'd1);
        #2;
        iResetN = 1'b0;
        #1;
        check("t6_busy",  64'(oBusy),   64'd0);
        check("t6_done",  64'(oDone),   64'd0);
        check("t6_rden",  64'(oRdEn),   64'd0);
        check("t6_valid", 64'(oValid),  64'd0);
        check("t6_last",  64'(oLast),   64'd0);
        check("t6_addr",  64'(oRdAddr), 64'd0);
        check("t6_data",  64'(oData),   64'd0);
        @(negedge iClock);
        #2;
        iResetN = 1'b1;
        repeat (5) @(negedge iClock);
        check("t6_no_done", 64'(done_cnt), 64'(d0));
        check("t6_idle_valid", 64'(oValid), 64'd0);
        run_cmd("t6_after", 9'h020, 10'd2, -1);
        check("final_credit", 64'(credit_err), 64'd0);
        check("final_stall_stable", 64'(stall_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
